memory_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_picker.sv | 32 +++
 rtl/memory_arbiter.sv | 132 +++++++++++++
 tb/tb_memory_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding, grant
// encoding and default bus widths.
package mem_arb_pkg;

   localparam int DEF_ADDR_W  = 28;
   localparam int DEF_BLOCK_W = 128;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SERVE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      GR_NONE = 2'd0,
      GR_INST = 2'd1,
      GR_DATA = 2'd2
   } grant_t;

endpackage

// File: rtl/mem_arb_picker.sv
// Winner selection between the instruction and data requesters.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN. When defined, contention
// goes to the requester that was not granted last; otherwise data always
// beats instruction.
module mem_arb_picker
   import mem_arb_pkg::*;
(
   input  logic   inst_req,
   input  logic   data_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
   input  grant_t last_grant,
`endif
   output grant_t winner
);

   // Pick the requester to serve next; NONE when nobody is asking.
   always_comb begin
      winner = GR_NONE;
      if (inst_req && data_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
         winner = (last_grant == GR_DATA) ? GR_INST : GR_DATA;
`else
         winner = GR_DATA;
`endif
      end else if (data_req) begin
         winner = GR_DATA;
      end else if (inst_req) begin
         winner = GR_INST;
      end
   end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one block-wide main memory port between the instruction-fetch and
// data-access paths. Requests are serialised through IDLE -> SERVE -> DONE;
// the requester not being finished sees BUSYWAIT high.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (round-robin on contention,
// tracked by last_grant). Without it, data has fixed priority.
module memory_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int BLOCK_W = DEF_BLOCK_W
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               INST_MEM_READ,
   input  logic [ADDR_W-1:0]  INST_MEM_ADDRESS,
   output logic [BLOCK_W-1:0] INST_MEM_READDATA,
   output logic               INST_MEM_BUSYWAIT,
   input  logic               DATA_MEM_READ,
   input  logic               DATA_MEM_WRITE,
   input  logic [ADDR_W-1:0]  DATA_MEM_ADDRESS,
   input  logic [BLOCK_W-1:0] DATA_MEM_WRITEDATA,
   output logic [BLOCK_W-1:0] DATA_MEM_READDATA,
   output logic               DATA_MEM_BUSYWAIT,
   output logic               MAIN_MEM_READ,
   output logic               MAIN_MEM_WRITE,
   output logic [ADDR_W-1:0]  MAIN_MEM_ADDRESS,
   output logic [BLOCK_W-1:0] MAIN_MEM_WRITEDATA,
   input  logic [BLOCK_W-1:0] MAIN_MEM_READDATA,
   input  logic               MAIN_MEM_BUSYWAIT
);

   state_t state;
   grant_t grant;
   grant_t winner;
   logic   serve_first;
   logic   data_req;

   assign data_req = DATA_MEM_READ | DATA_MEM_WRITE;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   grant_t last_grant;

   mem_arb_picker u_picker (
      .inst_req   (INST_MEM_READ),
      .data_req   (data_req),
      .last_grant (last_grant),
      .winner     (winner)
   );

   // Remember who was granted most recently; instruction so data wins first.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         last_grant <= GR_INST;
      end else if (state == ST_IDLE && winner != GR_NONE) begin
         last_grant <= winner;
      end
   end
`else
   mem_arb_picker u_picker (
      .inst_req (INST_MEM_READ),
      .data_req (data_req),
      .winner   (winner)
   );
`endif

   // A requester is released only during the DONE cycle of its own grant.
   assign INST_MEM_BUSYWAIT = INST_MEM_READ && !(state == ST_DONE && grant == GR_INST);
   assign DATA_MEM_BUSYWAIT = data_req && !(state == ST_DONE && grant == GR_DATA);

   // Arbitration FSM with registered main-memory strobes and return data.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state              <= ST_IDLE;
         grant              <= GR_NONE;
         serve_first        <= 1'b0;
         MAIN_MEM_READ      <= 1'b0;
         MAIN_MEM_WRITE     <= 1'b0;
         MAIN_MEM_ADDRESS   <= '0;
         MAIN_MEM_WRITEDATA <= '0;
         INST_MEM_READDATA  <= '0;
         DATA_MEM_READDATA  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (winner != GR_NONE) begin
                  grant       <= winner;
                  state       <= ST_SERVE;
                  serve_first <= 1'b1;
                  if (winner == GR_DATA) begin
                     // Read and write together is treated as a write.
                     MAIN_MEM_ADDRESS   <= DATA_MEM_ADDRESS;
                     MAIN_MEM_WRITEDATA <= DATA_MEM_WRITEDATA;
                     MAIN_MEM_WRITE     <= DATA_MEM_WRITE;
                     MAIN_MEM_READ      <= !DATA_MEM_WRITE;
                  end else begin
                     MAIN_MEM_ADDRESS <= INST_MEM_ADDRESS;
                     MAIN_MEM_READ    <= 1'b1;
                     MAIN_MEM_WRITE   <= 1'b0;
                  end
               end
            end
            ST_SERVE: begin
               serve_first <= 1'b0;
               // The memory's busy flag is not trusted in the strobe's first cycle.
               if (!serve_first && !MAIN_MEM_BUSYWAIT) begin
                  if (MAIN_MEM_READ) begin
                     // A withdrawn request lets the read finish but drops its result.
                     if (grant == GR_INST && INST_MEM_READ) begin
                        INST_MEM_READDATA <= MAIN_MEM_READDATA;
                     end
                     if (grant == GR_DATA && DATA_MEM_READ && !DATA_MEM_WRITE) begin
                        DATA_MEM_READDATA <= MAIN_MEM_READDATA;
                     end
                  end
                  MAIN_MEM_READ  <= 1'b0;
                  MAIN_MEM_WRITE <= 1'b0;
                  state          <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               grant <= GR_NONE;
            end
            default: begin
               state <= ST_IDLE;
               grant <= GR_NONE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: a latency-programmable main memory
// model, a scoreboard of expected main-memory operations, a vector table for
// single and contending requests, and hand-written multi-cycle sequences.
module tb_memory_arbiter;
   import mem_arb_pkg::*;

   localparam int AW = 28;
   localparam int BW = 128;

   logic          CLK = 1'b0;
   logic          RESET;
   logic          INST_MEM_READ;
   logic [AW-1:0] INST_MEM_ADDRESS;
   logic [BW-1:0] INST_MEM_READDATA;
   logic          INST_MEM_BUSYWAIT;
   logic          DATA_MEM_READ;
   logic          DATA_MEM_WRITE;
   logic [AW-1:0] DATA_MEM_ADDRESS;
   logic [BW-1:0] DATA_MEM_WRITEDATA;
   logic [BW-1:0] DATA_MEM_READDATA;
   logic          DATA_MEM_BUSYWAIT;
   logic          MAIN_MEM_READ;
   logic          MAIN_MEM_WRITE;
   logic [AW-1:0] MAIN_MEM_ADDRESS;
   logic [BW-1:0] MAIN_MEM_WRITEDATA;
   logic [BW-1:0] MAIN_MEM_READDATA;
   logic          MAIN_MEM_BUSYWAIT;

   memory_arbiter dut (
      .CLK                (CLK),
      .RESET              (RESET),
      .INST_MEM_READ      (INST_MEM_READ),
      .INST_MEM_ADDRESS   (INST_MEM_ADDRESS),
      .INST_MEM_READDATA  (INST_MEM_READDATA),
      .INST_MEM_BUSYWAIT  (INST_MEM_BUSYWAIT),
      .DATA_MEM_READ      (DATA_MEM_READ),
      .DATA_MEM_WRITE     (DATA_MEM_WRITE),
      .DATA_MEM_ADDRESS   (DATA_MEM_ADDRESS),
      .DATA_MEM_WRITEDATA (DATA_MEM_WRITEDATA),
      .DATA_MEM_READDATA  (DATA_MEM_READDATA),
      .DATA_MEM_BUSYWAIT  (DATA_MEM_BUSYWAIT),
      .MAIN_MEM_READ      (MAIN_MEM_READ),
      .MAIN_MEM_WRITE     (MAIN_MEM_WRITE),
      .MAIN_MEM_ADDRESS   (MAIN_MEM_ADDRESS),
      .MAIN_MEM_WRITEDATA (MAIN_MEM_WRITEDATA),
      .MAIN_MEM_READDATA  (MAIN_MEM_READDATA),
      .MAIN_MEM_BUSYWAIT  (MAIN_MEM_BUSYWAIT)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end else begin
         $display("ok   %s = %0h", name, act);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=completion", name);
   endtask

   // Default block content of main memory for a given index.
   function automatic logic [BW-1:0] pat(input logic [7:0] idx);
      if (idx == 8'h10) return 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
      return {4{24'hC0FFEE, idx}};
   endfunction

   // ---------------- main memory model ----------------
   int            mem_lat = 1;
   int            mem_cnt = 0;
   logic [BW-1:0] mem [256];
   bit            mem_written [256];

   assign MAIN_MEM_BUSYWAIT = (MAIN_MEM_READ | MAIN_MEM_WRITE) && (mem_cnt < mem_lat);
   assign MAIN_MEM_READDATA = mem_written[MAIN_MEM_ADDRESS[7:0]] ? mem[MAIN_MEM_ADDRESS[7:0]]
                                                                 : pat(MAIN_MEM_ADDRESS[7:0]);

   always @(posedge CLK) begin
      if (MAIN_MEM_WRITE && !MAIN_MEM_BUSYWAIT) begin
         mem[MAIN_MEM_ADDRESS[7:0]]         <= MAIN_MEM_WRITEDATA;
         mem_written[MAIN_MEM_ADDRESS[7:0]] <= 1'b1;
      end
      if (MAIN_MEM_READ | MAIN_MEM_WRITE) mem_cnt <= mem_cnt + 1;
      else                                mem_cnt <= 0;
   end

   // ---------------- reference contents (bench-side expectation) ----------------
   logic [BW-1:0] ref_mem [256];
   bit            ref_written [256];

   function automatic logic [BW-1:0] ref_read(input logic [AW-1:0] a);
      return ref_written[a[7:0]] ? ref_mem[a[7:0]] : pat(a[7:0]);
   endfunction

   // ---------------- scoreboard of main-memory operations ----------------
   typedef struct {
      bit            rd;
      bit            wr;
      logic [AW-1:0] addr;
      logic [BW-1:0] wdata;
   } op_t;

   op_t exp_q[$];
   int  seen_ops = 0;
   logic prev_strobe = 1'b0;

   function automatic op_t mk_op(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [BW-1:0] d);
      op_t o;
      o.rd = rd; o.wr = wr; o.addr = a; o.wdata = d;
      return o;
   endfunction

   always @(negedge CLK) begin : monitor
      op_t e;
      if ((MAIN_MEM_READ | MAIN_MEM_WRITE) && !prev_strobe) begin
         seen_ops++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL main_op unexpected actual=rd%0d/wr%0d@%0h required=none",
                     MAIN_MEM_READ, MAIN_MEM_WRITE, MAIN_MEM_ADDRESS);
         end else begin
            e = exp_q.pop_front();
            check("main_read",  {127'd0, MAIN_MEM_READ},  {127'd0, e.rd});
            check("main_write", {127'd0, MAIN_MEM_WRITE}, {127'd0, e.wr});
            check("main_addr",  {100'd0, MAIN_MEM_ADDRESS}, {100'd0, e.addr});
            if (e.wr) check("main_wdata", MAIN_MEM_WRITEDATA, e.wdata);
         end
      end
      prev_strobe = MAIN_MEM_READ | MAIN_MEM_WRITE;
   end

   // ---------------- vector table ----------------
   typedef struct {
      bit            inst_rd;
      logic [AW-1:0] inst_addr;
      bit            data_rd;
      bit            data_wr;
      logic [AW-1:0] data_addr;
      logic [BW-1:0] wdata;
      int            lat;
      int            exp_first;   // 1 = instruction completes first, 2 = data
   } vec_t;

   localparam int NV = 7;
   vec_t tbl [NV];

   logic [BW-1:0] last_data;
   logic [BW-1:0] last_inst;
   logic [BW-1:0] exp_data;
   logic [BW-1:0] exp_inst;
   vec_t          t;
   int            who;
   int            first_done;
   int            lat_cnt;
   int            target;
   bit            inst_p;
   bit            data_p;

   // Wait for BUSYWAIT low on one requester, counting cycles; -1 on timeout.
   task automatic wait_release(input bit is_inst, output int cycles);
      cycles = -1;
      for (int c = 1; c <= 60; c++) begin
         @(negedge CLK);
         if (is_inst ? !INST_MEM_BUSYWAIT : !DATA_MEM_BUSYWAIT) begin
            cycles = c;
            break;
         end
      end
   endtask

   task automatic pulse_reset();
      @(negedge CLK);
      RESET = 1'b1;
      @(negedge CLK);
      #1 RESET = 1'b0;
   endtask

   initial begin
      RESET = 1'b1;
      INST_MEM_READ = 1'b0; INST_MEM_ADDRESS = '0;
      DATA_MEM_READ = 1'b0; DATA_MEM_WRITE = 1'b0;
      DATA_MEM_ADDRESS = '0; DATA_MEM_WRITEDATA = '0;
      last_data = '0; last_inst = '0;

      tbl[0] = '{0, 28'h0, 1, 0, 28'h0000040, 128'h0, 2, 2};
      tbl[1] = '{1, 28'h0000030, 0, 0, 28'h0, 128'h0, 1, 1};
      tbl[2] = '{1, 28'h0000020, 0, 1, 28'h0000020, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1, 2};
      tbl[3] = '{0, 28'h0, 1, 1, 28'h0000050, 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA, 3, 2};
      tbl[4] = '{1, 28'h0000050, 0, 0, 28'h0, 128'h0, 1, 1};
      tbl[5] = '{1, 28'h0000060, 1, 0, 28'h0000061, 128'h0, 2, 2};
      tbl[6] = '{1, 28'hFFFFFFF, 0, 1, 28'hFFFFFFF, 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0001, 1, 2};

      // Reset state
      @(negedge CLK);
      @(negedge CLK);
      check("rst_main_read",  {127'd0, MAIN_MEM_READ}, 128'd0);
      check("rst_main_write", {127'd0, MAIN_MEM_WRITE}, 128'd0);
      check("rst_main_addr",  {100'd0, MAIN_MEM_ADDRESS}, 128'd0);
      check("rst_main_wdata", MAIN_MEM_WRITEDATA, 128'd0);
      check("rst_inst_rdata", INST_MEM_READDATA, 128'd0);
      check("rst_data_rdata", DATA_MEM_READDATA, 128'd0);
      check("rst_busy_idle",  {126'd0, INST_MEM_BUSYWAIT, DATA_MEM_BUSYWAIT}, 128'd0);
      #1 RESET = 1'b0;

      // Instruction read alone, memory busy 4 cycles
      mem_lat = 4;
      exp_q.push_back(mk_op(1, 0, 28'h0000010, '0));
      @(negedge CLK);
      INST_MEM_READ = 1'b1; INST_MEM_ADDRESS = 28'h0000010;
      wait_release(1, lat_cnt);
      check("t1_latency", lat_cnt, 6);
      check("t1_rdata", INST_MEM_READDATA, pat(8'h10));
      last_inst = pat(8'h10);
      @(negedge CLK);
      check("t1_busy_after_done", {127'd0, INST_MEM_BUSYWAIT}, 128'd1);
      INST_MEM_READ = 1'b0;

      // Table-driven single and contending requests
      for (int v = 0; v < NV; v++) begin
         t = tbl[v];
         mem_lat = t.lat;
         for (int k = 0; k < 2; k++) begin
            who = (k == 0) ? t.exp_first : 3 - t.exp_first;
            if (who == 2 && (t.data_rd || t.data_wr)) begin
               if (t.data_wr) begin
                  ref_mem[t.data_addr[7:0]] = t.wdata;
                  ref_written[t.data_addr[7:0]] = 1'b1;
                  exp_q.push_back(mk_op(0, 1, t.data_addr, t.wdata));
               end else begin
                  exp_data = ref_read(t.data_addr);
                  exp_q.push_back(mk_op(1, 0, t.data_addr, '0));
               end
            end
            if (who == 1 && t.inst_rd) begin
               exp_inst = ref_read(t.inst_addr);
               exp_q.push_back(mk_op(1, 0, t.inst_addr, '0));
            end
         end
         @(negedge CLK);
         INST_MEM_READ = t.inst_rd; INST_MEM_ADDRESS = t.inst_addr;
         DATA_MEM_READ = t.data_rd; DATA_MEM_WRITE = t.data_wr;
         DATA_MEM_ADDRESS = t.data_addr; DATA_MEM_WRITEDATA = t.wdata;
         inst_p = t.inst_rd; data_p = t.data_rd | t.data_wr; first_done = 0;
         for (int c = 0; c < 100 && (inst_p || data_p); c++) begin
            @(negedge CLK);
            if (data_p && !DATA_MEM_BUSYWAIT) begin
               if (t.data_wr) begin
                  check($sformatf("v%0d_data_keep", v), DATA_MEM_READDATA, last_data);
               end else begin
                  check($sformatf("v%0d_data_rdata", v), DATA_MEM_READDATA, exp_data);
                  last_data = exp_data;
               end
               DATA_MEM_READ = 1'b0; DATA_MEM_WRITE = 1'b0; data_p = 1'b0;
               if (first_done == 0) first_done = 2;
            end
            if (inst_p && !INST_MEM_BUSYWAIT) begin
               check($sformatf("v%0d_inst_rdata", v), INST_MEM_READDATA, exp_inst);
               last_inst = exp_inst;
               INST_MEM_READ = 1'b0; inst_p = 1'b0;
               if (first_done == 0) first_done = 1;
            end
         end
         if (inst_p || data_p) fail_now($sformatf("v%0d_completion", v));
         INST_MEM_READ = 1'b0; DATA_MEM_READ = 1'b0; DATA_MEM_WRITE = 1'b0;
         check($sformatf("v%0d_first_done", v), first_done, t.exp_first);
      end

      // Data read withdrawn during SERVE
      mem_lat = 4;
      exp_q.push_back(mk_op(1, 0, 28'h0000080, '0));
      @(negedge CLK);
      DATA_MEM_READ = 1'b1; DATA_MEM_ADDRESS = 28'h0000080;
      @(negedge CLK);
      @(negedge CLK);
      DATA_MEM_READ = 1'b0;
      lat_cnt = -1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge CLK);
         if (!MAIN_MEM_READ) begin lat_cnt = c; break; end
      end
      if (lat_cnt < 0) fail_now("t5_main_complete");
      check("t5_data_unchanged", DATA_MEM_READDATA, last_data);
      check("t5_data_busy", {127'd0, DATA_MEM_BUSYWAIT}, 128'd0);
      @(negedge CLK);
      mem_lat = 1;
      exp_q.push_back(mk_op(1, 0, 28'h0000090, '0));
      INST_MEM_READ = 1'b1; INST_MEM_ADDRESS = 28'h0000090;
      wait_release(1, lat_cnt);
      check("t5_min_latency", lat_cnt, 3);
      check("t5_inst_rdata", INST_MEM_READDATA, pat(8'h90));
      INST_MEM_READ = 1'b0;

      // Reset pulsed mid-SERVE of a data read, then re-issue
      mem_lat = 4;
      exp_q.push_back(mk_op(1, 0, 28'h0000070, '0));
      @(negedge CLK);
      @(negedge CLK);
      DATA_MEM_READ = 1'b1; DATA_MEM_ADDRESS = 28'h0000070;
      @(negedge CLK);
      @(negedge CLK);
      #2 RESET = 1'b1;
      #1;
      check("t4_main_read_drop", {127'd0, MAIN_MEM_READ}, 128'd0);
      check("t4_main_addr_clr", {100'd0, MAIN_MEM_ADDRESS}, 128'd0);
      check("t4_data_rdata_clr", DATA_MEM_READDATA, 128'd0);
      check("t4_inst_rdata_clr", INST_MEM_READDATA, 128'd0);
      check("t4_data_busy", {127'd0, DATA_MEM_BUSYWAIT}, 128'd1);
      exp_q.push_back(mk_op(1, 0, 28'h0000070, '0));
      @(negedge CLK);
      #1 RESET = 1'b0;
      wait_release(0, lat_cnt);
      if (lat_cnt < 0) fail_now("t4_reissue");
      check("t4_reissue_rdata", DATA_MEM_READDATA, pat(8'h70));
      DATA_MEM_READ = 1'b0;

      // Both requesting continuously for four grants, starting from reset
      pulse_reset();
      mem_lat = 1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_q.push_back(mk_op(1, 0, 28'h00000A0, '0));
      exp_q.push_back(mk_op(1, 0, 28'h00000B0, '0));
      exp_q.push_back(mk_op(1, 0, 28'h00000A0, '0));
      exp_q.push_back(mk_op(1, 0, 28'h00000B0, '0));
`else
      for (int k = 0; k < 4; k++) exp_q.push_back(mk_op(1, 0, 28'h00000A0, '0));
`endif
      target = seen_ops + 4;
      @(negedge CLK);
      DATA_MEM_READ = 1'b1; DATA_MEM_ADDRESS = 28'h00000A0;
      INST_MEM_READ = 1'b1; INST_MEM_ADDRESS = 28'h00000B0;
      for (int c = 0; c < 60 && seen_ops < target; c++) @(negedge CLK);
      DATA_MEM_READ = 1'b0; INST_MEM_READ = 1'b0;
      if (seen_ops < target) fail_now("t3_four_grants");
      repeat (5) @(negedge CLK);
      check("t3_ops_seen", seen_ops, target);
      check("t3_queue_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
